// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read, write, issue and pending signals of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            we0;
  logic [AW-1:0]   wa0;
  logic [XLEN-1:0] wd0;
  logic            we1;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd1;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            pend1;
  logic            pend2;
  logic            wr_conflict;

  modport master (
    output a1, a2, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd,
    input  rd1, rd2, pend1, pend2, wr_conflict
  );

  modport slave (
    input  a1, a2, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd,
    output rd1, rd2, pend1, pend2, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-read/two-write register file with write bypass and pending scoreboard
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BY = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             conflict_q;
  logic             ew0;
  logic             ew1;
  logic             same_addr;
  logic             hit0_1, hit1_1, hit0_2, hit1_2;
  logic             iss_set;

  // Nothing counts as written while reset is held, so bypass cannot leak data out of reset.
  assign ew0       = rst_n && bus.we0 && !(ZR && bus.wa0 == '0);
  assign ew1       = rst_n && bus.we1 && !(ZR && bus.wa1 == '0);
  assign same_addr = (bus.wa0 == bus.wa1);
  assign iss_set   = bus.iss_valid && !(ZR && bus.iss_rd == '0);

  assign hit0_1 = ew0 && (bus.wa0 == bus.a1);
  assign hit1_1 = ew1 && (bus.wa1 == bus.a1);
  assign hit0_2 = ew0 && (bus.wa0 == bus.a2);
  assign hit1_2 = ew1 && (bus.wa1 == bus.a2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ew0 && !(ew1 && same_addr)) begin
        regs[bus.wa0] <= bus.wd0;
      end
      if (ew1) begin
        regs[bus.wa1] <= bus.wd1;
      end
    end
  end

  // Issue is applied after the clears: a newer producer keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (ew0) begin
      pending_nxt[bus.wa0] = 1'b0;
    end
    if (ew1) begin
      pending_nxt[bus.wa1] = 1'b0;
    end
    if (iss_set) begin
      pending_nxt[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      conflict_q <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      conflict_q <= ew0 && ew1 && same_addr;
    end
  end

  always_comb begin
    bus.rd1 = regs[bus.a1];
    if (BY && hit1_1) begin
      bus.rd1 = bus.wd1;
    end else if (BY && hit0_1) begin
      bus.rd1 = bus.wd0;
    end
    if (ZR && bus.a1 == '0) begin
      bus.rd1 = '0;
    end
  end

  always_comb begin
    bus.rd2 = regs[bus.a2];
    if (BY && hit1_2) begin
      bus.rd2 = bus.wd1;
    end else if (BY && hit0_2) begin
      bus.rd2 = bus.wd0;
    end
    if (ZR && bus.a2 == '0) begin
      bus.rd2 = '0;
    end
  end

  assign bus.pend1 = pending[bus.a1] && !(BY && (hit0_1 || hit1_1)) && !(ZR && bus.a1 == '0);
  assign bus.pend2 = pending[bus.a2] && !(BY && (hit0_2 || hit1_2)) && !(ZR && bus.a2 == '0);
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - bench for regfile_mp with and without bypass
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_mp_if #(.XLEN(32), .AW(5)) ifa ();
  regfile_mp_if #(.XLEN(32), .AW(5)) ifb ();

  regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  assign ifb.a1        = ifa.a1;
  assign ifb.a2        = ifa.a2;
  assign ifb.we0       = ifa.we0;
  assign ifb.wa0       = ifa.wa0;
  assign ifb.wd0       = ifa.wd0;
  assign ifb.we1       = ifa.we1;
  assign ifb.wa1       = ifa.wa1;
  assign ifb.wd1       = ifa.wd1;
  assign ifb.iss_valid = ifa.iss_valid;
  assign ifb.iss_rd    = ifa.iss_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        iv;
    logic [4:0]  ird;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_p1;
    logic        e_p2;
    logic        e_cf;
  } vec_t;

  vec_t tbl[$];

  // Architectural state of the register file as seen by software.
  logic [31:0] mregs [32];
  bit          mpend [32];
  bit          mconf;

  function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic iv, input logic [4:0] ird,
                              input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                              input logic e_p1, input logic e_p2, input logic e_cf);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.a1 = a1; v.a2 = a2; v.iv = iv; v.ird = ird;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_p1 = e_p1; v.e_p2 = e_p2; v.e_cf = e_cf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 0) return 32'h0;
    if (byp && ifa.we1 && ifa.wa1 == a) return ifa.wd1;
    if (byp && ifa.we0 && ifa.wa0 == a) return ifa.wd0;
    return mregs[a];
  endfunction

  function automatic logic m_pend(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 0) return 1'b0;
    if (byp && ((ifa.we0 && ifa.wa0 == a) || (ifa.we1 && ifa.wa1 == a))) return 1'b0;
    return mpend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'h0;
      mpend[i] = 1'b0;
    end
    mconf = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    ifa.we0 = v.we0; ifa.wa0 = v.wa0; ifa.wd0 = v.wd0;
    ifa.we1 = v.we1; ifa.wa1 = v.wa1; ifa.wd1 = v.wd1;
    ifa.a1 = v.a1; ifa.a2 = v.a2;
    ifa.iss_valid = v.iv; ifa.iss_rd = v.ird;
  endtask

  task automatic settle_check(input string tag);
    #4;
    chk({tag, " byp rd1"}, ifa.rd1, m_rd(ifa.a1, 1'b1));
    chk({tag, " byp rd2"}, ifa.rd2, m_rd(ifa.a2, 1'b1));
    chk({tag, " byp pend1"}, 32'(ifa.pend1), 32'(m_pend(ifa.a1, 1'b1)));
    chk({tag, " byp pend2"}, 32'(ifa.pend2), 32'(m_pend(ifa.a2, 1'b1)));
    chk({tag, " byp conf"}, 32'(ifa.wr_conflict), 32'(mconf && rst_n));
    chk({tag, " nob rd1"}, ifb.rd1, m_rd(ifa.a1, 1'b0));
    chk({tag, " nob rd2"}, ifb.rd2, m_rd(ifa.a2, 1'b0));
    chk({tag, " nob pend1"}, 32'(ifb.pend1), 32'(m_pend(ifa.a1, 1'b0)));
    chk({tag, " nob pend2"}, 32'(ifb.pend2), 32'(m_pend(ifa.a2, 1'b0)));
    chk({tag, " nob conf"}, 32'(ifb.wr_conflict), 32'(mconf && rst_n));
  endtask

  task automatic clock_edge();
    bit e0, e1;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      e0 = ifa.we0 && ifa.wa0 != 0;
      e1 = ifa.we1 && ifa.wa1 != 0;
      mconf = e0 && e1 && ifa.wa0 == ifa.wa1;
      if (e0) begin mregs[ifa.wa0] = ifa.wd0; mpend[ifa.wa0] = 1'b0; end
      if (e1) begin mregs[ifa.wa1] = ifa.wd1; mpend[ifa.wa1] = 1'b0; end
      if (ifa.iss_valid && ifa.iss_rd != 0) mpend[ifa.iss_rd] = 1'b1;
    end
    #1;
  endtask

  vec_t idle;

  initial begin
    checks = 0;
    errors = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    rst_n = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    settle_check("reset");
    clock_edge();
    rst_n = 1'b1;

    //        we0 wa0 wd0            we1 wa1 wd1     a1 a2 iv ird  rd1            rd2            p1 p2 cf
    tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 0,        0, 0, 1, 0,   0,             0,             0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 1, 0,   0,             0,             0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0,   0,             0,             0, 0, 0));
    tbl.push_back(mk(1, 7, 32'hA5A5A5A5, 0, 0, 0,        0, 7, 0, 0,   0,             32'hA5A5A5A5,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        7, 7, 0, 0,   32'hA5A5A5A5,  32'hA5A5A5A5,  0, 0, 0));
    tbl.push_back(mk(1, 3, 32'h11,       1, 3, 32'h22,   3, 3, 0, 0,   32'h22,        32'h22,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        3, 4, 0, 0,   32'h22,        0,             0, 0, 1));
    tbl.push_back(mk(1, 3, 32'h11,       1, 4, 32'h22,   3, 4, 0, 0,   32'h11,        32'h22,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        3, 4, 0, 0,   32'h11,        32'h22,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        9, 0, 1, 9,   0,             0,             0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        9, 0, 0, 0,   0,             0,             1, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        9, 0, 0, 0,   0,             0,             1, 0, 0));
    tbl.push_back(mk(1, 9, 32'h99,       0, 0, 0,        9, 0, 0, 0,   32'h99,        0,             0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        9, 0, 0, 0,   32'h99,        0,             0, 0, 0));
    tbl.push_back(mk(1, 9, 32'h100,      0, 0, 0,        9, 0, 1, 9,   32'h100,       0,             0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        9, 0, 0, 0,   32'h100,       0,             1, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 9, 32'h200,  9, 9, 0, 0,   32'h200,       32'h200,       0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0,        9, 5, 0, 0,   32'h200,       0,             0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      settle_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl rd1", i), ifa.rd1, tbl[i].e_rd1);
      chk($sformatf("vec%0d tbl rd2", i), ifa.rd2, tbl[i].e_rd2);
      chk($sformatf("vec%0d tbl pend1", i), 32'(ifa.pend1), 32'(tbl[i].e_p1));
      chk($sformatf("vec%0d tbl pend2", i), 32'(ifa.pend2), 32'(tbl[i].e_p2));
      chk($sformatf("vec%0d tbl conf", i), 32'(ifa.wr_conflict), 32'(tbl[i].e_cf));
      clock_edge();
    end

    // Without bypass the old value is seen during the write, the new one afterwards.
    drive(mk(1, 7, 32'h5A5A5A5A, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    settle_check("nobyp_wr");
    chk("nobyp old rd2", ifb.rd2, 32'hA5A5A5A5);
    chk("byp fwd rd2", ifa.rd2, 32'h5A5A5A5A);
    clock_edge();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    settle_check("nobyp_after");
    chk("nobyp new rd2", ifb.rd2, 32'h5A5A5A5A);
    clock_edge();

    // Mid-run asynchronous reset, with a conflict flag raised and writes in flight.
    drive(mk(1, 5, 32'h0, 1, 5, 32'hDEADBEEF, 5, 0, 1, 5, 0, 0, 0, 0, 0));
    settle_check("pre_rst_wr");
    clock_edge();
    drive(mk(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst rd1", ifa.rd1, 32'hDEADBEEF);
    chk("pre_rst conf", 32'(ifa.wr_conflict), 32'h1);
    rst_n = 1'b0;
    drive(mk(1, 6, 32'h66, 0, 0, 0, 5, 6, 1, 6, 0, 0, 0, 0, 0));
    settle_check("in_rst");
    chk("in_rst rd1", ifa.rd1, 32'h0);
    chk("in_rst pend1", 32'(ifa.pend1), 32'h0);
    chk("in_rst conf", 32'(ifa.wr_conflict), 32'h0);
    clock_edge();
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 6, 5, 0, 0, 0, 0, 0, 0, 0));
    settle_check("post_rst");
    chk("post_rst rd1", ifa.rd1, 32'h0);
    chk("post_rst pend1", 32'(ifa.pend1), 32'h0);
    clock_edge();

    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = idle;
      v.we0 = 1'($urandom_range(0, 1));
      v.wa0 = 5'($urandom_range(0, 7));
      v.wd0 = $urandom;
      v.we1 = 1'($urandom_range(0, 1));
      v.wa1 = 5'($urandom_range(0, 7));
      v.wd1 = $urandom;
      v.a1  = 5'($urandom_range(0, 7));
      v.a2  = 5'($urandom_range(0, 7));
      v.iv  = 1'($urandom_range(0, 1));
      v.ird = 5'($urandom_range(0, 7));
      drive(v);
      settle_check($sformatf("rnd%0d", n));
      clock_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
